// File: rtl/axil_dmem_slave.sv
// AXI4-Lite responder for the core's word-organised data memory.
// Independent write (AW/W -> B) and read (AR -> R) FSMs share one synchronous RAM.
module axil_dmem_slave #(
  parameter int AXI_AWIDTH = 12,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  output logic [1:0]              AXI_BRESP,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  input  logic                    AXI_ARVALID,
  output logic                    AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  output logic [1:0]              AXI_RRESP,
  output logic                    AXI_RVALID,
  input  logic                    AXI_RREADY,
  output logic                    DBG_W_STATE,
  output logic                    DBG_R_STATE
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // VALID and READY are both 1; VALID/READY outputs depend only on registered
  // state (and NRST), never on an incoming VALID.

  localparam int IW    = AXI_AWIDTH - 2;
  localparam int DEPTH = 1 << IW;
  localparam int NB    = AXI_DWIDTH / 8;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [AXI_DWIDTH-1:0] mem [DEPTH];

  logic                  aw_held, w_held;
  logic [IW-1:0]         aw_idx_q;
  logic [AXI_DWIDTH-1:0] w_data_q;
  logic [NB-1:0]         w_strb_q;

  logic                  aw_hs, w_hs, commit, ar_hs;
  logic [IW-1:0]         wr_idx;
  logic [AXI_DWIDTH-1:0] wr_data;
  logic [NB-1:0]         wr_strb;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

  assign AXI_BRESP   = 2'b00;
  assign AXI_RRESP   = 2'b00;
  assign DBG_W_STATE = (w_state == W_RESP);
  assign DBG_R_STATE = (r_state == R_DATA);

  // Write side: a held beat takes precedence over the live bus for the commit.
  always_comb begin
    w_state_nxt = w_state;
    AXI_AWREADY = 1'b0;
    AXI_WREADY  = 1'b0;
    AXI_BVALID  = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    commit      = 1'b0;
    wr_idx      = aw_held ? aw_idx_q : AXI_AWADDR[AXI_AWIDTH-1:2];
    wr_data     = w_held ? w_data_q : AXI_WDATA;
    wr_strb     = w_held ? w_strb_q : AXI_WSTRB;
    case (w_state)
      W_IDLE: begin
        AXI_AWREADY = NRST && !aw_held;
        AXI_WREADY  = NRST && !w_held;
        aw_hs       = AXI_AWVALID && AXI_AWREADY;
        w_hs        = AXI_WVALID && AXI_WREADY;
        commit      = (aw_held || aw_hs) && (w_held || w_hs);
        if (commit) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        AXI_BVALID = 1'b1;
        if (AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= AXI_AWADDR[AXI_AWIDTH-1:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= AXI_WDATA;
          w_strb_q <= AXI_WSTRB;
        end
      end
    end
  end

  // Array is deliberately not reset; only enabled byte lanes are written.
  always_ff @(posedge CLK) begin
    if (NRST && commit) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read side.
  always_comb begin
    r_state_nxt = r_state;
    AXI_ARREADY = 1'b0;
    AXI_RVALID  = 1'b0;
    ar_hs       = 1'b0;
    case (r_state)
      R_IDLE: begin
        AXI_ARREADY = NRST;
        ar_hs       = AXI_ARVALID && AXI_ARREADY;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        AXI_RVALID = 1'b1;
        if (AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Non-blocking read of the array gives read-before-write on a same-edge collision.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_state   <= R_IDLE;
      AXI_RDATA <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) AXI_RDATA <= mem[AXI_ARADDR[AXI_AWIDTH-1:2]];
    end
  end

endmodule
